uart_frame_tx_ctrl: RTL and testbench



---
 rtl/uart_frame_tx_if.sv | 26 ++
 rtl/uart_frame_tx_ctrl.sv | 165 ++++++++++++++++
 tb/tb_uart_frame_tx_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_tx_if.sv
// Report-request and UART-transmitter handshake bundle for uart_frame_tx_ctrl.
// master = report source / transmitter side, slave = the frame controller.
interface uart_frame_tx_if;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [7:0]  rpt_flags;
  logic [7:0]  rpt_count;
  logic [15:0] rpt_x;
  logic [15:0] rpt_y;
  logic        uart_en;
  logic [7:0]  uart_din;
  logic        uart_tx_busy;
  logic        frame_busy;
  logic        frame_done;
  logic        err_timeout;

  modport master (
    output rpt_valid, rpt_flags, rpt_count, rpt_x, rpt_y, uart_tx_busy,
    input  rpt_ready, uart_en, uart_din, frame_busy, frame_done, err_timeout
  );

  modport slave (
    input  rpt_valid, rpt_flags, rpt_count, rpt_x, rpt_y, uart_tx_busy,
    output rpt_ready, uart_en, uart_din, frame_busy, frame_done, err_timeout
  );
endinterface

// File: rtl/uart_frame_tx_ctrl.sv
// Serialises one latched defect report as a fixed byte frame over the UART en/din/busy handshake.
// Optional trailing checksum byte enabled by defining UART_FRAME_CKSUM_EN.
module uart_frame_tx_ctrl #(
  parameter int         BUSY_TIMEOUT = 16,
  parameter logic [7:0] HDR0         = 8'h55,
  parameter logic [7:0] HDR1         = 8'hAA
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  uart_frame_tx_if.slave  bus
);

`ifdef UART_FRAME_CKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif
  localparam logic [7:0] TO_LAST = 8'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        uart_en_q, uart_en_d;
  logic [7:0]  uart_din_q, uart_din_d;
  logic        rpt_ready_q, rpt_ready_d;
  logic        frame_done_q, frame_done_d;
  logic        err_timeout_q, err_timeout_d;
  logic [7:0]  flags_q, flags_d;
  logic [7:0]  count_q, count_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic        accept;
  logic [3:0]  next_idx;
  logic [7:0]  next_byte;

`ifdef UART_FRAME_CKSUM_EN
  logic [7:0] cksum;
  assign cksum = flags_q + count_q + x_q[15:8] + x_q[7:0] + y_q[15:8] + y_q[7:0];
`endif

  assign next_idx = byte_idx_q + 4'd1;

  always_comb begin
    next_byte = HDR0;
    case (next_idx)
      4'd1: next_byte = HDR1;
      4'd2: next_byte = flags_q;
      4'd3: next_byte = count_q;
      4'd4: next_byte = x_q[15:8];
      4'd5: next_byte = x_q[7:0];
      4'd6: next_byte = y_q[15:8];
      4'd7: next_byte = y_q[7:0];
`ifdef UART_FRAME_CKSUM_EN
      4'd8: next_byte = cksum;
`endif
      default: next_byte = HDR0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    cnt_d         = cnt_q;
    uart_en_d     = uart_en_q;
    uart_din_d    = uart_din_q;
    frame_done_d  = 1'b0;
    err_timeout_d = 1'b0;
    accept        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rpt_valid && rpt_ready_q) begin
          accept     = 1'b1;
          state_d    = SEND;
          byte_idx_d = 4'd0;
          cnt_d      = 8'd0;
          uart_en_d  = 1'b1;
          uart_din_d = HDR0;
        end
      end
      SEND: begin
        // A busy already high on entry counts as the acknowledgement.
        if (bus.uart_tx_busy) begin
          state_d   = WAIT;
          uart_en_d = 1'b0;
          cnt_d     = 8'd0;
        end else if (cnt_q == TO_LAST) begin
          state_d       = IDLE;
          uart_en_d     = 1'b0;
          cnt_d         = 8'd0;
          err_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT: begin
        if (!bus.uart_tx_busy) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end else begin
            state_d    = SEND;
            byte_idx_d = next_idx;
            uart_en_d  = 1'b1;
            uart_din_d = next_byte;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    rpt_ready_d = (state_d == IDLE);
  end

  always_comb begin
    flags_d = flags_q;
    count_d = count_q;
    x_d     = x_q;
    y_d     = y_q;
    if (accept) begin
      flags_d = bus.rpt_flags;
      count_d = bus.rpt_count;
      x_d     = bus.rpt_x;
      y_d     = bus.rpt_y;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      byte_idx_q    <= 4'd0;
      cnt_q         <= 8'd0;
      uart_en_q     <= 1'b0;
      uart_din_q    <= 8'h00;
      rpt_ready_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      cnt_q         <= cnt_d;
      uart_en_q     <= uart_en_d;
      uart_din_q    <= uart_din_d;
      rpt_ready_q   <= rpt_ready_d;
      frame_done_q  <= frame_done_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Report payload is pure data and only meaningful after an accept.
  always_ff @(posedge sys_clk) begin
    flags_q <= flags_d;
    count_q <= count_d;
    x_q     <= x_d;
    y_q     <= y_d;
  end

  assign bus.rpt_ready   = rpt_ready_q;
  assign bus.uart_en     = uart_en_q;
  assign bus.uart_din    = uart_din_q;
  assign bus.frame_busy  = (state_q != IDLE);
  assign bus.frame_done  = frame_done_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_frame_tx_ctrl.sv
// Directed bench for uart_frame_tx_ctrl with a busy-flag transmitter model and a frame monitor.
module tb_uart_frame_tx_ctrl;
`ifdef UART_FRAME_CKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  uart_frame_tx_if bus();

  uart_frame_tx_ctrl dut (.sys_clk(clk), .sys_rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int en_rise = 0, en_hi = 0, done_cnt = 0, err_cnt = 0, stab_err = 0, rdy_busy_err = 0;
  bit bfm_on = 1'b1;
  int dly = 0, hold = 0;
  logic prev_en = 1'b0, prev_busy = 1'b0, prev_rst = 1'b0;
  logic [7:0] prev_din = 8'h00;

  // Monitor and transmitter model, both evaluated away from the active edge.
  always @(negedge clk) begin
    if (rst_n && prev_rst) begin
      if (bus.uart_en && !prev_en) begin
        en_rise++;
        got.push_back(bus.uart_din);
      end
      if (bus.uart_en) en_hi++;
      if (bus.frame_done) done_cnt++;
      if (bus.err_timeout) err_cnt++;
      if ((prev_en || prev_busy) && bus.uart_din !== prev_din) stab_err++;
      if (bus.frame_busy && bus.rpt_ready) rdy_busy_err++;
    end
    if (!rst_n) begin
      bus.uart_tx_busy = 1'b0;
      dly = 0;
      hold = 0;
    end else if (bfm_on) begin
      if (bus.uart_en && !prev_en) dly = 2;
      else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          bus.uart_tx_busy = 1'b1;
          hold = 20;
        end
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) bus.uart_tx_busy = 1'b0;
      end
    end
    prev_en = bus.uart_en;
    prev_busy = bus.uart_tx_busy;
    prev_din = bus.uart_din;
    prev_rst = rst_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input logic [7:0] f, input logic [7:0] c, input logic [15:0] x,
                           input logic [15:0] y);
    logic [7:0] s;
    exp_q.push_back(8'h55); exp_q.push_back(8'hAA);
    exp_q.push_back(f); exp_q.push_back(c);
    exp_q.push_back(x[15:8]); exp_q.push_back(x[7:0]);
    exp_q.push_back(y[15:8]); exp_q.push_back(y[7:0]);
    s = f + c + x[15:8] + x[7:0] + y[15:8] + y[7:0];
`ifdef UART_FRAME_CKSUM_EN
    exp_q.push_back(s);
`endif
  endtask

  task automatic chk_frames(input string tag);
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    if (got.size() == exp_q.size())
      for (int i = 0; i < exp_q.size(); i++) chk($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic send(input logic [7:0] f, input logic [7:0] c, input logic [15:0] x,
                      input logic [15:0] y, input bit keep);
    int n = 0;
    @(negedge clk);
    bus.rpt_flags = f; bus.rpt_count = c; bus.rpt_x = x; bus.rpt_y = y;
    bus.rpt_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_busy && n < 50);
    chk("accept", 32'(bus.frame_busy), 32'd1);
    if (!keep) bus.rpt_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!bus.frame_done && !bus.err_timeout && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("end_within_bound", 32'(bus.frame_done | bus.err_timeout), 32'd1);
  endtask

  task automatic clear_mon();
    got.delete(); exp_q.delete();
    en_rise = 0; en_hi = 0; done_cnt = 0; err_cnt = 0;
  endtask

  initial begin
    int n;
    bus.rpt_valid = 1'b0; bus.rpt_flags = 8'h00; bus.rpt_count = 8'h00;
    bus.rpt_x = 16'h0000; bus.rpt_y = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.rpt_ready), 32'd0);
    chk("rst_en", 32'(bus.uart_en), 32'd0);
    chk("rst_din", 32'(bus.uart_din), 32'h00);
    chk("rst_fbusy", 32'(bus.frame_busy), 32'd0);
    chk("rst_done", 32'(bus.frame_done), 32'd0);
    chk("rst_err", 32'(bus.err_timeout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.rpt_ready), 32'd1);

    // Nominal frame
    clear_mon();
    send(8'h01, 8'h03, 16'h0123, 16'h0456, 1'b0);
    chk("nom_first_din", 32'(bus.uart_din), 32'h55);
    chk("nom_first_en", 32'(bus.uart_en), 32'd1);
    wait_end();
    @(negedge clk);
    build_exp(8'h01, 8'h03, 16'h0123, 16'h0456);
    chk_frames("nom");
`ifdef UART_FRAME_CKSUM_EN
    chk("nom_cksum", 32'(got[got.size()-1]), 32'h82);
`endif
    chk("nom_done_cnt", 32'(done_cnt), 32'd1);
    chk("nom_err_cnt", 32'(err_cnt), 32'd0);
    chk("nom_en_rises", 32'(en_rise), 32'(NB));

    // Checksum wrap
    clear_mon();
    send(8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 1'b0);
    wait_end();
    @(negedge clk);
    build_exp(8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF);
    chk_frames("wrap");
`ifdef UART_FRAME_CKSUM_EN
    chk("wrap_cksum", 32'(got[got.size()-1]), 32'hFA);
`endif

    // Timeout: transmitter never answers
    bfm_on = 1'b0;
    clear_mon();
    send(8'h11, 8'h22, 16'h3344, 16'h5566, 1'b0);
    wait_end();
    chk("to_err_pulse", 32'(bus.err_timeout), 32'd1);
    chk("to_ready", 32'(bus.rpt_ready), 32'd1);
    chk("to_fbusy", 32'(bus.frame_busy), 32'd0);
    @(negedge clk);
    chk("to_err_width", 32'(bus.err_timeout), 32'd0);
    chk("to_en_cycles", 32'(en_hi), 32'd16);
    chk("to_err_cnt", 32'(err_cnt), 32'd1);
    chk("to_done_cnt", 32'(done_cnt), 32'd0);
    chk("to_en_rises", 32'(en_rise), 32'd1);
    bfm_on = 1'b1;

    // Back-to-back with fields changing during frame 1
    clear_mon();
    rdy_busy_err = 0;
    send(8'hA1, 8'hB2, 16'hC3D4, 16'hE5F6, 1'b1);
    @(negedge clk);
    bus.rpt_flags = 8'h12; bus.rpt_count = 8'h34; bus.rpt_x = 16'h5678; bus.rpt_y = 16'h9ABC;
    chk("b2b_ready_low", 32'(bus.rpt_ready), 32'd0);
    wait_end();
    chk("b2b_done1", 32'(bus.frame_done), 32'd1);
    chk("b2b_ready_idle", 32'(bus.rpt_ready), 32'd1);
    @(negedge clk);
    chk("b2b_f2_busy", 32'(bus.frame_busy), 32'd1);
    chk("b2b_f2_din", 32'(bus.uart_din), 32'h55);
    bus.rpt_valid = 1'b0;
    wait_end();
    @(negedge clk);
    build_exp(8'hA1, 8'hB2, 16'hC3D4, 16'hE5F6);
    build_exp(8'h12, 8'h34, 16'h5678, 16'h9ABC);
    chk_frames("b2b");
    chk("b2b_done_cnt", 32'(done_cnt), 32'd2);
    chk("b2b_ready_vs_busy", 32'(rdy_busy_err), 32'd0);

    // Reset during WAIT of byte idx4
    clear_mon();
    send(8'h01, 8'h02, 16'h7788, 16'h99AA, 1'b0);
    n = 0;
    while (!(bus.uart_tx_busy && !bus.uart_en && bus.uart_din == 8'h77) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached_idx4", 32'(bus.uart_din), 32'h77);
    rst_n = 1'b0;
    #1;
    chk("mid_en", 32'(bus.uart_en), 32'd0);
    chk("mid_din", 32'(bus.uart_din), 32'h00);
    chk("mid_fbusy", 32'(bus.frame_busy), 32'd0);
    chk("mid_ready", 32'(bus.rpt_ready), 32'd0);
    chk("mid_done", 32'(bus.frame_done), 32'd0);
    chk("mid_err", 32'(bus.err_timeout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_no_done", 32'(done_cnt), 32'd0);
    chk("mid_no_err", 32'(err_cnt), 32'd0);
    chk("mid_ready_after", 32'(bus.rpt_ready), 32'd1);
    clear_mon();
    send(8'h05, 8'h06, 16'h0708, 16'h090A, 1'b0);
    wait_end();
    @(negedge clk);
    build_exp(8'h05, 8'h06, 16'h0708, 16'h090A);
    chk_frames("post_rst");

    chk("din_stability", 32'(stab_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
